// File: rtl/pipe_output_merger.sv
// rtl/pipe_output_merger.sv - two-source FIFO buffering, round-robin merge and stall generation
module pipe_output_merger #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_data_1,
    input  logic              in_valid_1,
    input  logic [DATA_W-1:0] in_data_2,
    input  logic              in_valid_2,
    output logic              global_stall,
    output logic [DATA_W-1:0] out_data,
    output logic              out_src,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  count_1,
    output logic [CNT_W-1:0]  count_2,
    output logic              overflow_err
);
    localparam int AW = $clog2(DEPTH);
    typedef logic [AW-1:0] ptr_t;
    typedef logic [AW:0]   occ_t;

    logic [DATA_W-1:0] mem_q [2][DEPTH];
    logic [DATA_W-1:0] in_data [2];
    ptr_t              wr_ptr_q [2];
    ptr_t              wr_ptr_d [2];
    ptr_t              rd_ptr_q [2];
    ptr_t              rd_ptr_d [2];
    occ_t              occ_q [2];
    occ_t              occ_d [2];
    logic [CNT_W-1:0]  cnt_q [2];
    logic [CNT_W-1:0]  cnt_d [2];
    logic              stall_q, stall_d;
    logic              rr_q, rr_d;
    logic              ovf_q, ovf_d;
    logic [1:0]        in_valid, push, wr_en, pop, nonempty, full;
    logic              sel;
    logic              xfer;

    assign in_valid   = {in_valid_2, in_valid_1};
    assign in_data[0] = in_data_1;
    assign in_data[1] = in_data_2;

    // Arbitration depends only on register state, never on out_ready
    always_comb begin
        for (int k = 0; k < 2; k++) begin
            nonempty[k] = (occ_q[k] != occ_t'(0));
            full[k]     = (occ_q[k] == occ_t'(DEPTH));
        end
        if (nonempty[0] && nonempty[1]) begin
            sel = rr_q;
        end else begin
            sel = nonempty[1];
        end
    end

    assign out_valid = |nonempty;
    assign out_src   = sel;
    assign out_data  = mem_q[sel][rd_ptr_q[sel]];
    assign xfer      = out_valid && out_ready;

    always_comb begin
        stall_d = 1'b0;
        ovf_d   = ovf_q;
        for (int k = 0; k < 2; k++) begin
            push[k]     = in_valid[k] && !stall_q;
            wr_en[k]    = push[k] && !full[k];
            pop[k]      = xfer && ((k == 0) ? !sel : sel);
            occ_d[k]    = occ_q[k] + occ_t'(wr_en[k]) - occ_t'(pop[k]);
            wr_ptr_d[k] = wr_en[k] ? wr_ptr_q[k] + ptr_t'(1) : wr_ptr_q[k];
            rd_ptr_d[k] = pop[k] ? rd_ptr_q[k] + ptr_t'(1) : rd_ptr_q[k];
            cnt_d[k]    = (push[k] && (cnt_q[k] != '1)) ? cnt_q[k] + 1'b1 : cnt_q[k];
            if (occ_d[k] >= occ_t'(DEPTH - 1)) begin
                stall_d = 1'b1;
            end
            if (push[k] && full[k]) begin
                ovf_d = 1'b1;
            end
        end
        // A refused word pins the choice so out_* stays stable until taken
        if (xfer) begin
            rr_d = !sel;
        end else if (out_valid) begin
            rr_d = sel;
        end else begin
            rr_d = rr_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < 2; k++) begin
                wr_ptr_q[k] <= '0;
                rd_ptr_q[k] <= '0;
                occ_q[k]    <= '0;
                cnt_q[k]    <= '0;
            end
            stall_q <= 1'b0;
            rr_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                wr_ptr_q[k] <= wr_ptr_d[k];
                rd_ptr_q[k] <= rd_ptr_d[k];
                occ_q[k]    <= occ_d[k];
                cnt_q[k]    <= cnt_d[k];
            end
            stall_q <= stall_d;
            rr_q    <= rr_d;
            ovf_q   <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (wr_en[k]) begin
                mem_q[k][wr_ptr_q[k]] <= in_data[k];
            end
        end
    end

    assign global_stall = stall_q;
    assign count_1      = cnt_q[0];
    assign count_2      = cnt_q[1];
    assign overflow_err = ovf_q;
endmodule

// File: doc/pipe_output_merger.md
Name: pipe_output_merger

Overview:
- Downstream consumer of the dual-pipeline block. Takes the two pipeline result streams (data + valid), buffers each in a small FIFO, and merges them into one ready/valid stream using round-robin arbitration.
- Owns generation of global_stall back to the pipelines. Neither pipeline has output buffering, so backpressure from the sink must freeze both pipelines before either FIFO overflows.

Parameters:
- DATA_W, 32, width of each pipeline result word.
- DEPTH, 4, entries per source FIFO; power of 2, minimum 4.
- CNT_W, 16, width of the per-source accepted-word counters (saturating).

Ports:
- clk, input, 1, system clock; all state on posedge.
- reset, input, 1, asynchronous active-high reset.
- in_data_1, input, DATA_W, pipeline 1 result.
- in_valid_1, input, 1, pipeline 1 result valid.
- in_data_2, input, DATA_W, pipeline 2 result.
- in_valid_2, input, 1, pipeline 2 result valid.
- global_stall, output, 1, registered stall to both pipelines.
- out_data, output, DATA_W, merged result word.
- out_src, output, 1, source of out_data (0 = pipeline 1, 1 = pipeline 2).
- out_valid, output, 1, merged word valid.
- out_ready, input, 1, sink accepts the word when out_valid && out_ready.
- count_1, output, CNT_W, words accepted from pipeline 1 (saturating).
- count_2, output, CNT_W, words accepted from pipeline 2 (saturating).
- overflow_err, output, 1, sticky error flag: a push was attempted into a full FIFO.

Behaviour:
- Reset (asynchronous, any time, including mid-operation):
  - Both FIFOs are emptied and pointers zeroed.
  - global_stall=0, out_valid=0, count_1=count_2=0, overflow_err=0.
  - Round-robin pointer selects pipeline 1 first.
- Capture:
  - push_k = in_valid_k && !global_stall.
  - While global_stall=1 the pipelines hold their frozen outputs. Those repeated words are never re-captured.
- Stall generation (registered):
  - global_stall <= (next_occ_1 >= DEPTH-1) || (next_occ_2 >= DEPTH-1).
  - next_occ is the occupancy after this cycle's push/pop.
  - Consequence: whenever global_stall=0, each FIFO has at least 2 free entries. A push never overflows in correct operation.
  - global_stall deasserts the cycle after both occupancies drop to DEPTH-2 or below.
- FIFOs:
  - Circular buffers with pointer wrap at DEPTH.
  - Push and pop on the same FIFO in the same cycle leaves occupancy unchanged.
  - No bypass: a word pushed at edge N is first visible at out_* after edge N.
- Arbitration:
  - Only one FIFO non-empty: present its head.
  - Both non-empty: present the head of the FIFO selected by the round-robin pointer.
  - The pointer flips only on a completed transfer (out_valid && out_ready), and then points to the other source.
- Output:
  - out_valid = either FIFO non-empty.
  - out_data and out_src are driven from the selected FIFO head and register state only; no combinational path from out_ready.
  - While out_valid && !out_ready, out_data, out_src and the arbitration choice must stay stable.
- Counters:
  - count_k increments on each push_k and saturates at all-ones.
- Error:
  - overflow_err is set if a push targets a full FIFO; the push is then dropped.
  - It clears only on reset and must never assert in legal operation.
- Latency: input-to-output is 1 cycle minimum when the FIFO is empty and out_ready=1.

Test Plan:
- Reset, then in_valid_1=in_valid_2=1 every cycle, out_ready=1, inputs incrementing from 1 and 101:
  - Output alternates 1(src0), 101(src1), 2, 102, ...
  - global_stall rises once the FIFOs fill.
  - count_1 and count_2 differ by at most 1.
  - overflow_err=0.
- out_ready=0 with both inputs valid every cycle:
  - Each FIFO receives 3 words (DEPTH=4).
  - global_stall=1 from the cycle after the third push.
  - No further pushes occur; out_data holds 1, src0, stable for 20 cycles.
  - count_1=count_2=3.
- From the full-stalled state, raise out_ready=1:
  - Drain order is 1, 101, 2, 102, 3, 103.
  - global_stall drops after one pop from each FIFO.
  - The frozen inputs are not duplicated in the output stream.
- Only in_valid_1 pulses, data 0xA5A5A5A5, one cycle, FIFO empty:
  - out_valid=1 on the next cycle with out_data=0xA5A5A5A5, out_src=0.
  - out_valid=0 on the cycle after that.
- Assert reset asynchronously mid-clock with both FIFOs at occupancy 2:
  - out_valid, global_stall, count_1 and count_2 all go to 0 immediately, without waiting for a clock edge.
  - After release, the first output comes from src0.
- Force 2^CNT_W+5 pushes on pipeline 1:
  - count_1 saturates at 0xFFFF and does not wrap.
